legv8_fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the LEGv8 control unit.
- Holds the program counter and issues requests to instruction memory over a req/ack handshake.
- Presents each fetched 32-bit instruction to the control unit through a valid/ready pair.
- Computes the next PC from the redirect the control unit returns with each consumed instruction: sequential, PC-relative branch, or register target.

---
 rtl/legv8_pkg.sv | 20 ++
 rtl/legv8_next_pc.sv | 22 ++
 rtl/legv8_fetch_unit.sv | 107 ++++++++++
 tb/tb_legv8_fetch_unit.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/legv8_pkg.sv
// Shared LEGv8 fetch types: state encoding, next-PC select codes and bus widths.
// Pure declarations; no latency and no backpressure.
package legv8_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_e;

  // Code 2'b11 is deliberately unnamed; it behaves as sequential.
  localparam logic [1:0] PC_SEL_SEQ    = 2'b00;
  localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
  localparam logic [1:0] PC_SEL_REG    = 2'b10;

endpackage

// File: rtl/legv8_next_pc.sv
// Combinational next-PC target: pc+4, pc-relative word branch, or word-aligned register target.
// Zero latency; there is no handshake, so there is no backpressure.
module legv8_next_pc
  import legv8_pkg::*;
(
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [1:0]        pc_sel_i,
  input  logic [ADDR_W-1:0] branch_offset_i,
  input  logic [ADDR_W-1:0] reg_target_i,
  output logic [ADDR_W-1:0] next_pc_o
);

  always_comb begin
    next_pc_o = pc_i + 64'd4;
    case (pc_sel_i)
      PC_SEL_BRANCH: next_pc_o = pc_i + (branch_offset_i << 2);
      PC_SEL_REG:    next_pc_o = reg_target_i & ~64'h3;
      default:       next_pc_o = pc_i + 64'd4;
    endcase
  end

endmodule

// File: rtl/legv8_fetch_unit.sv
// Fetch stage: req/ack to instruction memory, valid/ready to the control unit, sticky timeout fault.
// Min 2 cycles per instruction (REQ+ack, HOLD+ready); instruction/pc hold while instr_ready is low.
module legv8_fetch_unit
  import legv8_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          TIMEOUT  = 16
) (
  input  logic               clock,
  input  logic               reset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instruction,
  output logic [ADDR_W-1:0]  pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic [1:0]         pc_sel,
  input  logic [ADDR_W-1:0]  branch_offset,
  input  logic [ADDR_W-1:0]  reg_target,
  output logic               fetch_fault
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  fetch_state_e        state_q;
  logic [ADDR_W-1:0]   fetch_pc_q;
  logic [ADDR_W-1:0]   fetch_pc_d;
  logic [ADDR_W-1:0]   pc_q;
  logic [INSTR_W-1:0]  instr_q;
  logic                instr_valid_q;
  logic                imem_req_q;
  logic [ADDR_W-1:0]   imem_addr_q;
  logic                fault_q;
  logic [7:0]          cnt_q;

  // Target is derived from the presented pc, not fetch_pc.
  legv8_next_pc u_next_pc (
    .pc_i            (pc_q),
    .pc_sel_i        (pc_sel),
    .branch_offset_i (branch_offset),
    .reg_target_i    (reg_target),
    .next_pc_o       (fetch_pc_d)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      fetch_pc_q    <= RESET_PC;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      imem_req_q    <= 1'b0;
      imem_addr_q   <= RESET_PC;
      fault_q       <= 1'b0;
      cnt_q         <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_q     <= ST_REQ;
          imem_req_q  <= 1'b1;
          imem_addr_q <= fetch_pc_q;
        end
        ST_REQ: begin
          if (imem_ack) begin
            instr_q       <= imem_rdata;
            pc_q          <= fetch_pc_q;
            cnt_q         <= '0;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b1;
            state_q       <= ST_HOLD;
          end else if (cnt_q == CNT_LAST) begin
            imem_req_q <= 1'b0;
            fault_q    <= 1'b1;
            state_q    <= ST_FAULT;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        ST_HOLD: begin
          if (instr_ready) begin
            fetch_pc_q    <= fetch_pc_d;
            imem_addr_q   <= fetch_pc_d;
            imem_req_q    <= 1'b1;
            instr_valid_q <= 1'b0;
            state_q       <= ST_REQ;
          end
        end
        ST_FAULT: begin
          imem_req_q    <= 1'b0;
          instr_valid_q <= 1'b0;
          fault_q       <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = imem_addr_q;
  assign instruction = instr_q;
  assign pc          = pc_q;
  assign instr_valid = instr_valid_q;
  assign fetch_fault = fault_q;

endmodule

// File: tb/tb_legv8_fetch_unit.sv
// Bench for legv8_fetch_unit: directed and randomized fetch/consume traffic against a PC model,
// plus a second instance with a short timeout and non-zero reset PC for the fault path.
module tb_legv8_fetch_unit;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [63:0] pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [1:0]  pc_sel;
  logic [63:0] branch_offset;
  logic [63:0] reg_target;
  logic        fetch_fault;

  logic        t_reset;
  logic        t_req;
  logic [63:0] t_addr;
  logic        t_ack;
  logic [31:0] t_rdata;
  logic [31:0] t_instr;
  logic [63:0] t_pc;
  logic        t_valid;
  logic        t_ready;
  logic [1:0]  t_sel;
  logic [63:0] t_off;
  logic [63:0] t_tgt;
  logic        t_fault;

  legv8_fetch_unit dut (
    .clock(clock), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instruction(instruction), .pc(pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .pc_sel(pc_sel),
    .branch_offset(branch_offset), .reg_target(reg_target), .fetch_fault(fetch_fault)
  );

  legv8_fetch_unit #(.RESET_PC(64'h40), .TIMEOUT(4)) dut_to (
    .clock(clock), .reset(t_reset), .imem_req(t_req), .imem_addr(t_addr),
    .imem_ack(t_ack), .imem_rdata(t_rdata), .instruction(t_instr), .pc(t_pc),
    .instr_valid(t_valid), .instr_ready(t_ready), .pc_sel(t_sel),
    .branch_offset(t_off), .reg_target(t_tgt), .fetch_fault(t_fault)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory contents: fixed ADD word at 0, an address-derived pattern elsewhere.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == 64'h0) return 32'h8B1F0040;
    return a[31:0] ^ 32'h5A3C96E1 ^ {a[47:32], a[63:48]};
  endfunction

  // Reference next-PC from the architectural rules, using plain arithmetic.
  function automatic logic [63:0] model_next(input logic [63:0] cur, input logic [1:0] sel,
                                             input logic [63:0] off, input logic [63:0] tgt);
    case (sel)
      2'b01:   return cur + off * 64'd4;
      2'b10:   return tgt - (tgt % 64'd4);
      default: return cur + 64'd4;
    endcase
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Entered at a negedge with the DUT in REQ; leaves at a negedge with the DUT in HOLD.
  task automatic do_fetch(input int waits, input logic [63:0] exp_addr);
    chk("req_up", 64'(imem_req), 64'd1);
    chk("req_addr", imem_addr, exp_addr);
    for (int i = 0; i < waits; i++) begin
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      @(negedge clock);
      chk("req_stable", 64'(imem_req), 64'd1);
      chk("addr_stable", imem_addr, exp_addr);
      chk("valid_during_wait", 64'(instr_valid), 64'd0);
    end
    imem_ack   = 1'b1;
    imem_rdata = mem_word(exp_addr);
    @(negedge clock);
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    chk("valid_after_ack", 64'(instr_valid), 64'd1);
    chk("instr", 64'(instruction), 64'(mem_word(exp_addr)));
    chk("pc", pc, exp_addr);
    chk("req_drop", 64'(imem_req), 64'd0);
  endtask

  // Stalls for `holds` cycles (with stray acks and noisy redirect inputs), then consumes.
  task automatic consume(input int holds, input logic [63:0] cur, input logic [1:0] sel,
                         input logic [63:0] off, input logic [63:0] tgt,
                         output logic [63:0] nxt);
    for (int i = 0; i < holds; i++) begin
      instr_ready   = 1'b0;
      imem_ack      = 1'b1;
      imem_rdata    = $urandom;
      pc_sel        = 2'($urandom_range(0, 3));
      branch_offset = rnd64();
      reg_target    = rnd64();
      @(negedge clock);
      chk("hold_valid", 64'(instr_valid), 64'd1);
      chk("hold_instr", 64'(instruction), 64'(mem_word(cur)));
      chk("hold_pc", pc, cur);
      chk("hold_no_req", 64'(imem_req), 64'd0);
    end
    imem_ack      = 1'b0;
    instr_ready   = 1'b1;
    pc_sel        = sel;
    branch_offset = off;
    reg_target    = tgt;
    @(negedge clock);
    instr_ready   = 1'b0;
    pc_sel        = 2'($urandom_range(0, 3));
    branch_offset = rnd64();
    reg_target    = rnd64();
    nxt = model_next(cur, sel, off, tgt);
    chk("valid_drop", 64'(instr_valid), 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] cur;
    logic [63:0] nxt;
    logic [63:0] off;
    logic [1:0]  sel;

    reset = 1'b0; imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
    pc_sel = 2'b00; branch_offset = '0; reg_target = '0;
    t_reset = 1'b0; t_ack = 1'b0; t_rdata = 32'hDEADBEEF; t_ready = 1'b0;
    t_sel = 2'b00; t_off = '0; t_tgt = '0;

    repeat (2) @(negedge clock);
    chk("rst_req", 64'(imem_req), 64'd0);
    chk("rst_valid", 64'(instr_valid), 64'd0);
    chk("rst_fault", 64'(fetch_fault), 64'd0);
    chk("rst_addr", imem_addr, 64'h0);
    chk("rst_pc", pc, 64'h0);
    chk("rst_instr", 64'(instruction), 64'd0);

    reset = 1'b1;
    #1 chk("idle_no_req", 64'(imem_req), 64'd0);
    @(negedge clock);

    // Zero-wait memory, consumed immediately: 0, 4, 8, 12 on every second cycle.
    cur = 64'h0;
    for (int k = 0; k < 4; k++) begin
      do_fetch(0, 64'(4 * k));
      consume(0, 64'(4 * k), 2'b00, rnd64(), rnd64(), nxt);
    end
    chk("add_word_seen", 64'(mem_word(64'h0)), 64'h8B1F0040);

    // Three wait states, then a four-cycle stall, then redirect to 0x100.
    do_fetch(3, 64'h10);
    consume(4, 64'h10, 2'b10, rnd64(), 64'h100, nxt);

    do_fetch(0, 64'h100);
    consume(0, 64'h100, 2'b01, -64'sd2, rnd64(), nxt);
    do_fetch(0, 64'hF8);
    consume(0, 64'hF8, 2'b10, rnd64(), 64'h100, nxt);
    do_fetch(0, 64'h100);
    consume(0, 64'h100, 2'b10, rnd64(), 64'h2003, nxt);
    do_fetch(0, 64'h2000);
    consume(0, 64'h2000, 2'b10, rnd64(), 64'h100, nxt);
    do_fetch(0, 64'h100);
    consume(0, 64'h100, 2'b11, rnd64(), rnd64(), nxt);
    do_fetch(0, 64'h104);
    consume(0, 64'h104, 2'b10, rnd64(), 64'hFFFF_FFFF_FFFF_FFFF, nxt);
    do_fetch(0, 64'hFFFF_FFFF_FFFF_FFFC);
    consume(0, 64'hFFFF_FFFF_FFFF_FFFC, 2'b00, rnd64(), rnd64(), nxt);
    do_fetch(0, 64'h0);
    chk("add_instr", 64'(instruction), 64'h8B1F0040);

    // Randomized traffic against the model.
    cur = 64'h0;
    for (int k = 0; k < 24; k++) begin
      sel = 2'($urandom_range(0, 3));
      off = ($urandom_range(0, 1) == 1) ? 64'($signed($urandom_range(0, 400)) - 200) : rnd64();
      consume($urandom_range(0, 3), cur, sel, off, rnd64(), nxt);
      cur = nxt;
      do_fetch($urandom_range(0, 3), cur);
    end

    // Async reset between edges while in HOLD, then while in REQ.
    #2 reset = 1'b0;
    #1 chk("arst_hold_valid", 64'(instr_valid), 64'd0);
    chk("arst_hold_pc", pc, 64'h0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    do_fetch(0, 64'h0);
    consume(0, 64'h0, 2'b10, rnd64(), 64'h300, nxt);
    imem_ack = 1'b0;
    @(negedge clock);
    chk("req_before_arst", 64'(imem_req), 64'd1);
    #2 reset = 1'b0;
    #1 chk("arst_req", 64'(imem_req), 64'd0);
    chk("arst_valid", 64'(instr_valid), 64'd0);
    chk("arst_fault", 64'(fetch_fault), 64'd0);
    chk("arst_addr", imem_addr, 64'h0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    do_fetch(0, 64'h0);

    // Timeout path on the second instance (TIMEOUT=4, RESET_PC=0x40).
    t_reset = 1'b1;
    @(negedge clock);
    chk("to_req_1", 64'(t_req), 64'd1);
    chk("to_addr", t_addr, 64'h40);
    repeat (3) @(negedge clock);
    chk("to_req_4", 64'(t_req), 64'd1);
    chk("to_no_fault_yet", 64'(t_fault), 64'd0);
    @(negedge clock);
    chk("to_fault", 64'(t_fault), 64'd1);
    chk("to_req_drop", 64'(t_req), 64'd0);
    chk("to_valid", 64'(t_valid), 64'd0);
    t_ack = 1'b1; t_ready = 1'b1;
    repeat (3) @(negedge clock);
    chk("to_fault_sticky", 64'(t_fault), 64'd1);
    chk("to_req_stays_low", 64'(t_req), 64'd0);
    chk("to_valid_stays_low", 64'(t_valid), 64'd0);
    t_ack = 1'b0; t_ready = 1'b0;
    #2 t_reset = 1'b0;
    #1 chk("to_fault_cleared", 64'(t_fault), 64'd0);
    @(negedge clock);
    t_reset = 1'b1;
    @(negedge clock);
    chk("to_restart_req", 64'(t_req), 64'd1);
    chk("to_restart_addr", t_addr, 64'h40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
